// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: re-arms the receiver after each frame, buffers good bytes
// in a first-word-fall-through FIFO and keeps saturating error statistics.
//
// state   | meaning
// IDLE    | receiver not armed; waiting for enable
// ARM     | rx_start pulse to receiver, timeout timer loaded
// WAIT    | frame in progress; watch for done, errors or timeout
// PUSH    | write latched byte into FIFO
// RECOVER | wait for receiver to go quiet before re-arming
module uart_rx_ctrl #(
    parameter int DATA_WD     = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int CNT_WD      = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          clear_stats,
    input  logic                          rx_done,
    input  logic                          rx_busy,
    input  logic                          parity_err_in,
    input  logic                          framing_err_in,
    input  logic [DATA_WD-1:0]            rx_data,
    output logic                          rx_start,
    output logic [DATA_WD-1:0]            m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [CNT_WD-1:0]             parity_cnt,
    output logic [CNT_WD-1:0]             framing_cnt,
    output logic                          overrun,
    output logic                          timeout
);

    localparam int PTR_WD = $clog2(FIFO_DEPTH);
    localparam int TMR_WD = $clog2(TIMEOUT_CYC);

    localparam logic [4:0] S_IDLE    = 5'b00001;
    localparam logic [4:0] S_ARM     = 5'b00010;
    localparam logic [4:0] S_WAIT    = 5'b00100;
    localparam logic [4:0] S_PUSH    = 5'b01000;
    localparam logic [4:0] S_RECOVER = 5'b10000;

    logic [4:0]          state, state_nxt;
    logic [TMR_WD-1:0]   tmr;
    logic                tmr_tc;
    logic [DATA_WD-1:0]  rx_byte;
    logic                wait_chk;
    logic                rx_quiet;

    logic [DATA_WD-1:0]  mem [FIFO_DEPTH];
    logic [PTR_WD-1:0]   wr_ptr, rd_ptr;
    logic                push, pop, full, wr_en;

    assign tmr_tc   = (tmr == '0);
    assign wait_chk = (state == S_WAIT) && !rx_done;
    assign rx_quiet = !rx_busy && !rx_done && !parity_err_in && !framing_err_in;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (enable) state_nxt = S_ARM;
            S_ARM:     state_nxt = S_WAIT;
            S_WAIT: begin
                if (rx_done)
                    state_nxt = S_PUSH;
                else if (framing_err_in || parity_err_in || tmr_tc)
                    state_nxt = S_RECOVER;
            end
            S_PUSH:    state_nxt = S_RECOVER;
            S_RECOVER: if (rx_quiet) state_nxt = enable ? S_ARM : S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // rx_start is registered from the next state so it coincides exactly with ARM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            rx_start <= 1'b0;
            tmr      <= '0;
            rx_byte  <= '0;
        end else begin
            state    <= state_nxt;
            rx_start <= (state_nxt == S_ARM);
            if (state == S_ARM)
                tmr <= TMR_WD'(TIMEOUT_CYC - 1);
            else if (state == S_WAIT && !tmr_tc)
                tmr <= tmr - 1'b1;
            if (state == S_WAIT && rx_done)
                rx_byte <= rx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_cnt  <= '0;
            framing_cnt <= '0;
            overrun     <= 1'b0;
            timeout     <= 1'b0;
        end else if (clear_stats) begin
            parity_cnt  <= '0;
            framing_cnt <= '0;
            overrun     <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            if (wait_chk && parity_err_in && parity_cnt != '1)
                parity_cnt <= parity_cnt + 1'b1;
            if (wait_chk && framing_err_in && framing_cnt != '1)
                framing_cnt <= framing_cnt + 1'b1;
            if (wait_chk && !parity_err_in && !framing_err_in && tmr_tc)
                timeout <= 1'b1;
            if (push && full && !pop)
                overrun <= 1'b1;
        end
    end

    assign push    = (state == S_PUSH);
    assign m_valid = (fifo_count != '0);
    assign full    = (fifo_count == ($clog2(FIFO_DEPTH) + 1)'(FIFO_DEPTH));
    assign pop     = m_valid && m_ready;
    // a full FIFO still accepts a byte when the head leaves in the same cycle
    assign wr_en   = push && (!full || pop);
    assign m_data  = m_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= rx_byte;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule
